// File: rtl/sfu_pkg.sv
// Shared types and fp16 helpers for the special-function datapath.
package sfu_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      FIN   = 3'd3,
      DONE  = 3'd4
   } acc_state_t;

   localparam int unsigned FP16_SIGN    = 15;
   localparam int unsigned FP16_EXP_HI  = 14;
   localparam int unsigned FP16_EXP_LO  = 10;
   localparam int unsigned FP16_MAN_HI  = 9;
   localparam int unsigned FP16_MAN_LO  = 0;
   localparam logic [4:0]  FP16_EXP_MAX = 5'd31;
   localparam logic [15:0] FP16_ZERO    = 16'h0000;
   localparam logic [15:0] FP16_QNAN    = 16'h7E00;

   // Divide by 2**k through the exponent; results that would go subnormal flush to signed zero.
   function automatic logic [15:0] fp16_mean(input logic [15:0] v, input logic [4:0] k);
      logic [4:0]  e;
      logic [15:0] r;
      e = v[FP16_EXP_HI:FP16_EXP_LO];
      if (e == FP16_EXP_MAX)
         r = v;
      else if (e > k)
         r = {v[FP16_SIGN], e - k, v[FP16_MAN_HI:FP16_MAN_LO]};
      else
         r = {v[FP16_SIGN], 15'b0};
      return r;
   endfunction

endpackage

// File: rtl/sq_sum_acc_adder_fp16.sv
// Pipelined fp16 adder (round-to-nearest-even, subnormals supported); ADD_LAT register stages.
module adder_fp16
   import sfu_pkg::*;
#(
   parameter int unsigned ADD_LAT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] op_a,
   input  logic [15:0] op_b,
   output logic [15:0] res_o
);

   function automatic logic [15:0] fp16_add(input logic [15:0] x, input logic [15:0] y);
      logic [15:0] a, b, r;
      logic [4:0]  ea, eb, d, lsh;
      logic [13:0] ma, mb, mb_al, n;
      logic [28:0] sh;
      logic [14:0] s, mag;
      logic [3:0]  p;
      logic [5:0]  e_r;
      logic        nan_x, nan_y, inf_x, inf_y, rnd;
      a = x; b = y; r = FP16_ZERO;
      ea = '0; eb = '0; d = '0; lsh = '0;
      ma = '0; mb = '0; mb_al = '0; n = '0;
      sh = '0; s = '0; mag = '0; p = '0; e_r = '0; rnd = 1'b0;
      nan_x = (x[14:10] == FP16_EXP_MAX) && (x[9:0] != '0);
      nan_y = (y[14:10] == FP16_EXP_MAX) && (y[9:0] != '0);
      inf_x = (x[14:10] == FP16_EXP_MAX) && (x[9:0] == '0);
      inf_y = (y[14:10] == FP16_EXP_MAX) && (y[9:0] == '0);
      if (nan_x || nan_y || (inf_x && inf_y && (x[15] != y[15])))
         r = FP16_QNAN;
      else if (inf_x)
         r = x;
      else if (inf_y)
         r = y;
      else begin
         if (x[14:0] < y[14:0]) begin
            a = y; b = x;
         end
         ea = (a[14:10] == '0) ? 5'd1 : a[14:10];
         eb = (b[14:10] == '0) ? 5'd1 : b[14:10];
         ma = {|a[14:10], a[9:0], 3'b000};
         mb = {|b[14:10], b[9:0], 3'b000};
         d  = ea - eb;
         // Three guard bits plus a sticky folded into the LSB keep RNE exact for subtraction.
         sh    = {mb, 15'b0} >> ((d > 5'd15) ? 5'd15 : d);
         mb_al = sh[28:15] | {13'b0, |sh[14:0]};
         s = (a[15] == b[15]) ? ({1'b0, ma} + {1'b0, mb_al}) : ({1'b0, ma} - {1'b0, mb_al});
         if (s == '0)
            r = {a[15] & b[15], 15'b0};
         else begin
            for (int unsigned i = 0; i < 15; i++)
               if (s[i]) p = 4'(i);
            if (p == 4'd14) begin
               n   = s[14:1] | {13'b0, s[0]};
               e_r = {1'b0, ea} + 6'd1;
            end else begin
               lsh = 5'd13 - {1'b0, p};
               if (lsh > ea - 5'd1) lsh = ea - 5'd1;
               n   = s[13:0] << lsh;
               e_r = n[13] ? ({1'b0, ea} - {1'b0, lsh}) : 6'd0;
            end
            if (e_r >= 6'd31)
               r = {a[15], FP16_EXP_MAX, 10'b0};
            else begin
               // Rounding carry ripples into the exponent, covering subnormal->normal and overflow to Inf.
               rnd = n[2] & (n[1] | n[0] | n[3]);
               mag = {e_r[4:0], n[12:3]} + {14'b0, rnd};
               r   = {a[15], mag};
            end
         end
      end
      return r;
   endfunction

   logic [15:0] op_a_q, op_b_q, res_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a_q <= '0;
         op_b_q <= '0;
      end else begin
         op_a_q <= op_a;
         op_b_q <= op_b;
      end
   end

   always_comb res_c = fp16_add(op_a_q, op_b_q);

   generate
      if (ADD_LAT == 1) begin : g_nopipe
         assign res_o = res_c;
      end else begin : g_pipe
         logic [ADD_LAT-2:0][15:0] pipe;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pipe <= '0;
            end else begin
               pipe[0] <= res_c;
               for (int unsigned i = 1; i < ADD_LAT - 1; i++)
                  pipe[i] <= pipe[i-1];
            end
         end
         assign res_o = pipe[ADD_LAT-2];
      end
   endgenerate

endmodule

// File: rtl/sq_sum_acc.sv
// Sequential fp16 accumulator: sums array elements in index order and derives the mean.
module sq_sum_acc
   import sfu_pkg::*;
#(
   parameter int unsigned data_width = 16,
   parameter int unsigned data_cnt   = 64,
   parameter int unsigned ADD_LAT    = 2
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start,
   input  logic [data_cnt-1:0][data_width-1:0]  array,
   output logic                                 busy,
   output logic                                 done,
   output logic [15:0]                          sum,
   output logic [15:0]                          mean
);

   localparam int unsigned K      = $clog2(data_cnt);
   localparam int unsigned IDX_W  = (K < 1) ? 1 : K;
   localparam int unsigned WCNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(data_cnt - 1);
   localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(ADD_LAT - 1);

   acc_state_t        state, state_nxt;
   logic [15:0]       acc, op_a, op_b, add_res;
   logic [IDX_W-1:0]  idx;
   logic [WCNT_W-1:0] wcnt;
   logic              wait_last;

   assign wait_last = (wcnt == WAIT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      op_a      = '0;
      op_b      = '0;
      case (state)
         IDLE, DONE: if (start) state_nxt = ISSUE;
         ISSUE: begin
            op_a      = acc;
            op_b      = array[idx];
            state_nxt = WAIT;
         end
         WAIT: if (wait_last) state_nxt = (idx == IDX_LAST) ? FIN : ISSUE;
         FIN:     state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc  <= '0;
         idx  <= '0;
         wcnt <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         sum  <= FP16_ZERO;
         mean <= FP16_ZERO;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  acc  <= '0;
                  idx  <= '0;
                  done <= 1'b0;
                  busy <= 1'b1;
               end
            end
            ISSUE: wcnt <= '0;
            WAIT: begin
               if (wait_last) begin
                  acc <= add_res;
                  if (idx != IDX_LAST) idx <= idx + 1'b1;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            FIN: begin
               sum  <= acc;
               mean <= fp16_mean(acc, 5'(K));
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   adder_fp16 #(
      .ADD_LAT(ADD_LAT)
   ) u_add (
      .clk   (clk),
      .rst_n (rst_n),
      .op_a  (op_a),
      .op_b  (op_b),
      .res_o (add_res)
   );

endmodule

// File: tb/tb_sq_sum_acc.sv
// Directed self-checking bench for sq_sum_acc with data_cnt=4, ADD_LAT=2.
module tb_sq_sum_acc;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [3:0][15:0] array = '0;
   logic             busy, done;
   logic [15:0]      sum, mean;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [15:0] held_sum = 16'h0000;
   logic [15:0] held_mean = 16'h0000;

   always #5 clk = ~clk;

   sq_sum_acc #(
      .data_width(16),
      .data_cnt  (4),
      .ADD_LAT   (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .array (array),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .mean  (mean)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Accept a start, verify busy/done each cycle, then the result 13 cycles after acceptance.
   task automatic run(input string tag, input logic [15:0] exp_sum, input logic [15:0] exp_mean,
                      input int unsigned repulse);
      start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, " c0 busy"}, {15'b0, busy}, 16'd1);
      check({tag, " c0 done"}, {15'b0, done}, 16'd0);
      check({tag, " c0 sum hold"}, sum, held_sum);
      check({tag, " c0 mean hold"}, mean, held_mean);
      for (int unsigned c = 1; c <= 12; c++) begin
         if (c == repulse) start = 1'b1;
         tick();
         start = 1'b0;
         check({tag, " busy"}, {15'b0, busy}, 16'd1);
         check({tag, " done"}, {15'b0, done}, 16'd0);
      end
      tick();
      check({tag, " c13 done"}, {15'b0, done}, 16'd1);
      check({tag, " c13 busy"}, {15'b0, busy}, 16'd0);
      check({tag, " sum"}, sum, exp_sum);
      check({tag, " mean"}, mean, exp_mean);
      held_sum  = exp_sum;
      held_mean = exp_mean;
   endtask

   initial begin
      #12;
      check("rst busy", {15'b0, busy}, 16'd0);
      check("rst done", {15'b0, done}, 16'd0);
      check("rst sum", sum, 16'h0000);
      check("rst mean", mean, 16'h0000);
      tick();
      rst_n = 1'b1;
      array = {16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
      repeat (3) tick();
      check("idle busy", {15'b0, busy}, 16'd0);
      check("idle done", {15'b0, done}, 16'd0);
      check("idle sum", sum, 16'h0000);

      run("ones", 16'h4400, 16'h3C00, 0);

      array = {16'hC000, 16'h4200, 16'h4000, 16'h3C00};
      run("mixed", 16'h4400, 16'h3C00, 0);

      array = {16'h3C00, 16'h7C00, 16'h3C00, 16'h3C00};
      run("inf", 16'h7C00, 16'h7C00, 0);

      array = {16'h0400, 16'h0400, 16'h0400, 16'h0400};
      run("minnorm", 16'h0C00, 16'h0400, 0);

      array = {16'h0001, 16'h0001, 16'h0001, 16'h0001};
      run("subnorm", 16'h0004, 16'h0000, 0);

      array = {16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
      run("repulse", 16'h4400, 16'h3C00, 5);

      array = {16'h4000, 16'h4000, 16'h4000, 16'h4000};
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (6) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst busy", {15'b0, busy}, 16'd0);
      check("midrst done", {15'b0, done}, 16'd0);
      check("midrst sum", sum, 16'h0000);
      check("midrst mean", mean, 16'h0000);
      held_sum  = 16'h0000;
      held_mean = 16'h0000;
      tick();
      rst_n = 1'b1;
      tick();
      run("postrst", 16'h4800, 16'h4000, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
